// File: rtl/saw_tx_ctrl.sv
// Stop-and-wait ARQ transmit controller: latches a word, sequences the CRC unit, sends
// {seq, data, crc} and retransmits on NAK/timeout. Define SAW_RETRY_LIMIT_EN to bound retries.
module saw_tx_ctrl #(
    parameter int unsigned DW      = 6,
    parameter int unsigned CRCW    = 3,
    parameter int unsigned TIMEOUT = 16
`ifdef SAW_RETRY_LIMIT_EN
    ,
    parameter int unsigned MAX_RETRY = 3
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    output logic                  crc_start,
    output logic [DW-1:0]         crc_data,
    input  logic                  crc_done,
    input  logic [CRCW-1:0]       crc_val,
    output logic                  tx_valid,
    output logic [DW+CRCW:0]      tx_frame,
    input  logic                  tx_ready,
    input  logic                  ack_valid,
    input  logic                  ack_nak,
    input  logic                  ack_seq,
    output logic                  done,
    output logic                  fail,
    output logic [1:0]            retry_cnt
);

    localparam int unsigned BW = 1 + DW + CRCW;
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StCrc,
        StSend,
        StWaitAck,
        StFail
    } state_e;

    state_e          state;
    logic            seq;
    logic [DW-1:0]   data_r;
    logic [BW-1:0]   frame_r;
    logic [TW-1:0]   timer;

    logic ack_match;
    logic resend_req;

    // Responses carrying the other sequence bit are stale duplicates.
    assign ack_match  = ack_valid && (ack_seq == seq);
    assign resend_req = (ack_match && ack_nak) || (timer == TW'(TIMEOUT - 1));

    assign in_ready = (state == StIdle);
    assign tx_valid = (state == StSend);
    assign tx_frame = frame_r;
    assign crc_data = data_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            seq       <= 1'b0;
            data_r    <= '0;
            frame_r   <= '0;
            timer     <= '0;
            crc_start <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= 2'd0;
        end else begin
            crc_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        data_r    <= in_data;
                        crc_start <= 1'b1;
                        state     <= StCrc;
                    end
                end
                StCrc: begin
                    if (crc_done) begin
                        frame_r <= {seq, data_r, crc_val};
                        state   <= StSend;
                    end
                end
                StSend: begin
                    if (tx_ready) begin
                        timer <= '0;
                        state <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    timer <= timer + TW'(1);
                    // A matching ACK wins over a timeout landing in the same cycle.
                    if (ack_match && !ack_nak) begin
                        seq       <= ~seq;
                        done      <= 1'b1;
                        retry_cnt <= 2'd0;
                        state     <= StIdle;
                    end else if (resend_req) begin
`ifdef SAW_RETRY_LIMIT_EN
                        if (32'(retry_cnt) == MAX_RETRY) begin
                            fail  <= 1'b1;
                            state <= StFail;
                        end else begin
                            retry_cnt <= (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
                            state     <= StSend;
                        end
`else
                        retry_cnt <= (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;
                        state     <= StSend;
`endif
                    end
                end
                StFail: begin
                    state <= StFail;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saw_tx_ctrl.sv
// Directed bench for saw_tx_ctrl: table of full ACKed transfers plus timeout, NAK,
// duplicate, ACK/timeout race, retry-limit and mid-frame reset sequences.
module tb_saw_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_ready;
    logic       crc_start;
    logic [5:0] crc_data;
    logic       crc_done;
    logic [2:0] crc_val;
    logic       tx_valid;
    logic [9:0] tx_frame;
    logic       tx_ready;
    logic       ack_valid;
    logic       ack_nak;
    logic       ack_seq;
    logic       done;
    logic       fail;
    logic [1:0] retry_cnt;

    int n_cmp = 0;
    int n_err = 0;

    saw_tx_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .crc_start (crc_start),
        .crc_data  (crc_data),
        .crc_done  (crc_done),
        .crc_val   (crc_val),
        .tx_valid  (tx_valid),
        .tx_frame  (tx_frame),
        .tx_ready  (tx_ready),
        .ack_valid (ack_valid),
        .ack_nak   (ack_nak),
        .ack_seq   (ack_seq),
        .done      (done),
        .fail      (fail),
        .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] data;
        logic [2:0] crc;
        int         crc_dly;
        int         ack_dly;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 1);
        check({tag, "_tx_valid"}, 32'(tx_valid), 0);
        check({tag, "_crc_start"}, 32'(crc_start), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_fail"}, 32'(fail), 0);
        check({tag, "_retry"}, 32'(retry_cnt), 0);
        check({tag, "_frame"}, 32'(tx_frame), 0);
    endtask

    // Accept a word, return CRC one cycle after crc_start, complete handshake.
    // Returns just after the handshake edge (first WAIT_ACK cycle).
    task automatic send_to_wait(input logic [5:0] d, input logic [2:0] c);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        tick();
        crc_done = 1'b1;
        crc_val  = c;
        tick();
        crc_done = 1'b0;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    // Wait n cycles expecting tx_valid to stay low the whole time.
    task automatic quiet(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (tx_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 0);
    endtask

    task automatic ack(input logic nak, input logic s);
        ack_valid = 1'b1;
        ack_nak   = nak;
        ack_seq   = s;
        tick();
        ack_valid = 1'b0;
        ack_nak   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; crc_done = 1'b0; crc_val = '0;
        tx_ready = 1'b0; ack_valid = 1'b0; ack_nak = 1'b0; ack_seq = 1'b0;

        // frame = {seq, data, crc}; seq alternates 0,1,0,1 across the table
        vecs[0] = '{6'h15, 3'b101, 2, 5, 10'h0AD};
        vecs[1] = '{6'h2A, 3'b011, 1, 1, 10'h353};
        vecs[2] = '{6'h3F, 3'b000, 3, 2, 10'h1F8};
        vecs[3] = '{6'h00, 3'b111, 1, 7, 10'h207};

        do_reset();
        check_reset_vals("reset");

        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_data  = vecs[v].data;
            tick();
            in_valid = 1'b0;
            in_data  = ~vecs[v].data;
            check($sformatf("v%0d_crc_start", v), 32'(crc_start), 1);
            check($sformatf("v%0d_crc_data", v), 32'(crc_data), 32'(vecs[v].data));
            check($sformatf("v%0d_in_ready_lo", v), 32'(in_ready), 0);
            for (int i = 0; i < vecs[v].crc_dly; i++) tick();
            check($sformatf("v%0d_crc_start_pulse", v), 32'(crc_start), 0);
            crc_done = 1'b1;
            crc_val  = vecs[v].crc;
            tick();
            crc_done = 1'b0;
            crc_val  = 3'b000;
            check($sformatf("v%0d_tx_valid", v), 32'(tx_valid), 1);
            check($sformatf("v%0d_tx_frame", v), 32'(tx_frame), 32'(vecs[v].frame));
            tx_ready = 1'b1;
            tick();
            tx_ready = 1'b0;
            check($sformatf("v%0d_tx_valid_lo", v), 32'(tx_valid), 0);
            for (int i = 1; i < vecs[v].ack_dly; i++) tick();
            ack(1'b0, vecs[v].frame[9]);
            check($sformatf("v%0d_done", v), 32'(done), 1);
            check($sformatf("v%0d_in_ready", v), 32'(in_ready), 1);
            check($sformatf("v%0d_retry", v), 32'(retry_cnt), 0);
            tick();
            check($sformatf("v%0d_done_pulse", v), 32'(done), 0);
        end

        // Matching ACK in the same cycle the timer reaches TIMEOUT-1 (seq=0)
        send_to_wait(6'h21, 3'b110);
        check("race_frame", 32'(tx_frame), 32'h10E);
        for (int i = 0; i < 15; i++) tick();
        ack(1'b0, 1'b0);
        check("race_done", 32'(done), 1);
        check("race_tx_valid", 32'(tx_valid), 0);
        check("race_retry", 32'(retry_cnt), 0);
        tick();
        check("race_no_resend", 32'(tx_valid), 0);

        // Retransmission sequence on seq=1 frame
        send_to_wait(6'h0C, 3'b010);
        quiet("to1_quiet", 15);
        tick();
        check("to1_tx_valid", 32'(tx_valid), 1);
        check("to1_frame", 32'(tx_frame), 32'h262);
        check("to1_retry", 32'(retry_cnt), 1);

        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        ack(1'b1, 1'b1);
        check("nak_tx_valid", 32'(tx_valid), 1);
        check("nak_retry", 32'(retry_cnt), 2);
        check("nak_frame", 32'(tx_frame), 32'h262);

        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        ack(1'b0, 1'b0);
        check("dup_ack_done", 32'(done), 0);
        check("dup_ack_tx", 32'(tx_valid), 0);
        ack(1'b1, 1'b0);
        check("dup_nak_tx", 32'(tx_valid), 0);
        quiet("dup_quiet", 13);
        tick();
        check("to2_tx_valid", 32'(tx_valid), 1);
        check("to2_retry", 32'(retry_cnt), 3);

        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        quiet("to3_quiet", 15);
        tick();
`ifdef SAW_RETRY_LIMIT_EN
        check("lim_fail", 32'(fail), 1);
        check("lim_tx_valid", 32'(tx_valid), 0);
        check("lim_in_ready", 32'(in_ready), 0);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        in_valid = 1'b0;
        check("lim_fail_sticky", 32'(fail), 1);
        check("lim_in_ready_sticky", 32'(in_ready), 0);
        check("lim_crc_start", 32'(crc_start), 0);
`else
        check("unl_tx_valid", 32'(tx_valid), 1);
        check("unl_retry_sat", 32'(retry_cnt), 3);
        check("unl_fail", 32'(fail), 0);
        check("unl_frame", 32'(tx_frame), 32'h262);
`endif

        // Reset while waiting on a seq=1 frame
        do_reset();
        check_reset_vals("rst2");
        send_to_wait(6'h01, 3'b001);
        ack(1'b0, 1'b0);
        check("pre_done", 32'(done), 1);
        send_to_wait(6'h02, 3'b100);
        check("pre_msb", 32'(tx_frame[9]), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_vals("midrst");
        in_valid = 1'b1;
        in_data  = 6'h03;
        tick();
        in_valid = 1'b0;
        tick();
        crc_done = 1'b1;
        crc_val  = 3'b011;
        tick();
        crc_done = 1'b0;
        check("post_rst_frame", 32'(tx_frame), 32'h01B);
        check("post_rst_tx_valid", 32'(tx_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/saw_tx_ctrl.md
# saw_tx_ctrl

Stop-and-wait ARQ transmit controller. It accepts one data word at a time from upstream and sequences the external CRC unit to build a frame of {seq, data, crc}. It then sends the frame over the channel handshake and runs the retransmission timer. It retransmits on NAK or timeout until the matching ACK arrives. It sits between the SAW transmitter FSM's data source and the CRC/frame/counter datapath.

## Interface
- DW, 6, payload data width
- CRCW, 3, CRC width; frame width BW = 1 + DW + CRCW (10 by default)
- TIMEOUT, 16, WAIT_ACK cycles before retransmit; must be ≥ 2
- MAX_RETRY, 3, retransmissions allowed before FAIL (used only with SAW_RETRY_LIMIT_EN)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream word available
- in_data  in  DW  upstream word
- in_ready  out  1  controller can accept a word (state IDLE)
- crc_start  out  1  one-cycle pulse: CRC unit starts on crc_data
- crc_data  out  DW  latched payload
- crc_done  in  1  CRC result valid (pulse)
- crc_val  in  CRCW  CRC result
- tx_valid  out  1  frame offered to channel
- tx_frame  out  BW  {seq, data, crc}, seq in the MSB
- tx_ready  in  1  channel accepts frame
- ack_valid  in  1  response from receiver
- ack_nak  in  1  1 = NAK, 0 = ACK (qualified by ack_valid)
- ack_seq  in  1  sequence bit of the response
- done  out  1  one-cycle pulse: frame acknowledged
- fail  out  1  sticky: retry limit exceeded
- retry_cnt  out  2  retransmissions of the current frame (saturates at 3)

## Operation
- States: IDLE, CRC, SEND, WAIT_ACK, FAIL.
- IDLE: in_ready=1. When in_valid=1, latch in_data into data_r, pulse crc_start in the next cycle, and go to CRC.
- CRC: wait for crc_done. On crc_done, latch frame_r = {seq, data_r, crc_val} and go to SEND. crc_data holds data_r throughout.
- SEND: tx_valid=1 and tx_frame=frame_r, held stable until tx_ready. On the handshake cycle, clear the timer and go to WAIT_ACK.
- WAIT_ACK: timer increments every cycle.
  - ack_valid & !ack_nak & ack_seq==seq: toggle seq, pulse done, clear retry_cnt, go to IDLE.
  - ack_valid & ack_nak & ack_seq==seq, or timer==TIMEOUT-1: retransmit.
  - Any response with ack_seq≠seq is a duplicate and is ignored; the timer keeps running.
- Retransmit: increment retry_cnt and go to SEND with the same frame_r. The CRC is not recomputed and seq is unchanged.
- FAIL: all handshake outputs are 0 and fail=1. Only rst exits FAIL.
- Precedence: a valid matching ACK beats a timeout in the same cycle. in_valid is ignored outside IDLE.
- Arithmetic: timer is $clog2(TIMEOUT) bits and is cleared on SEND→WAIT_ACK. retry_cnt saturates at 3.

## Timing
- Reset values: state=IDLE, seq=0, tx_valid=0, crc_start=0, done=0, fail=0, retry_cnt=0, timer=0, frame_r=0. in_ready reads 1 in the first cycle after rst deasserts.
- Accept at cycle T. crc_start is high at T+1; state is CRC from T+1.
- crc_done at cycle C gives tx_valid=1 from C+1.
- tx handshake at cycle S is followed by WAIT_ACK from S+1 with timer=0. With no response, the timeout fires at S+TIMEOUT and tx_valid is high again at S+TIMEOUT+1.
- An ACK at cycle A gives done=1 at A+1, in_ready=1 at A+1, and the toggled seq visible at A+1.
- rst mid-operation abandons the frame and restores all reset values, including seq=0.

## Configuration
- SAW_RETRY_LIMIT_EN
  - Defined: a retransmit request with retry_cnt==MAX_RETRY goes to FAIL instead of SEND and sets fail=1.
  - Undefined: retries are unlimited, FAIL is unreachable, fail is tied to 0, and retry_cnt still counts and saturates.

## Test plan
- Basic: in_data=6'h15 and crc_val=3'b101 (crc_done 2 cycles after crc_start), tx_ready=1, ACK seq=0 five cycles later → tx_frame=10'h0AD, done pulses, seq becomes 1, second word goes out with MSB=1.
- Timeout: no response with TIMEOUT=16 → identical tx_frame re-offered exactly 17 cycles after the first handshake, retry_cnt=1.
- NAK with seq match → retransmit next cycle. NAK or ACK with seq mismatch → ignored, timer continues.
- Same-cycle matching ACK and timeout → done=1, no retransmit, retry_cnt=0.
- SAW_RETRY_LIMIT_EN defined, MAX_RETRY=3, never ACK → four transmissions total, then fail=1 and in_ready=0 until rst. Without the macro, transmissions continue indefinitely and fail=0.
- rst asserted in WAIT_ACK with seq=1 → next cycle all outputs at reset values, in_ready=1, next frame MSB=0.
